serialtx_arb: RTL
=================

# serialtx_arb

Round-robin transmit scheduler that shares one `serialtx` PISO shift register between `N_REQ` byte producers. It picks one pending requester, loads that requester's byte into the serializer with a one-cycle latch pulse, then holds the serializer's transmit enable for exactly 8 cycles. It sits directly in front of `serialtx` and drives that block's `i_data`, `i_latchen` and `i_txen`. It also tells downstream logic which requester owns the bits currently on the line.

## Interface
- `N_REQ`, default 4: number of requesters, range 2..16.
- `IDW`, default `$clog2(N_REQ)`: owner index width.
- `i_clk`  in  1: single clock.
- `i_rst`  in  1: synchronous, active-high reset.
- `i_req`  in  N_REQ: per-requester "byte pending"; held high until acked.
- `i_data`  in  8*N_REQ: flat byte bus; requester k on bits [8k+7:8k].
- `o_ack`  out  N_REQ: one-hot, one-cycle pulse; the byte from that requester has been consumed.
- `o_data`  out  8: byte to `serialtx.i_data`.
- `o_latchen`  out  1: to `serialtx.i_latchen`.
- `o_txen`  out  1: to `serialtx.i_txen`.
- `o_owner`  out  IDW: index of the requester being serialized.
- `o_busy`  out  1: high in LATCH and SHIFT.

## Operation
- States: IDLE, LATCH, SHIFT. There is a 3-bit bit counter `cnt`.
- IDLE
  - If any `i_req` bit is high, a winner is picked.
  - On the same edge: `o_data` <= `i_data[winner]`, `o_owner` <= winner, and the state goes to LATCH.
  - Otherwise the block stays in IDLE.
- LATCH (1 cycle)
  - `o_latchen`=1, `o_ack[o_owner]`=1, `o_txen`=0.
  - Next state is SHIFT with `cnt`=0.
- SHIFT (8 cycles)
  - `o_txen`=1 and `cnt` increments each cycle.
  - In the cycle with `cnt`=7, arbitration runs again.
    - If a request is pending: load the new winner exactly as in IDLE and go to LATCH.
    - If no request is pending: go to IDLE.
- `o_latchen` and `o_txen` are never high in the same cycle. `serialtx` uses blocking assignments, so overlap would shift the new byte.
- Arbitration is sampled only in IDLE or in SHIFT with `cnt`=7. Requests in LATCH or in SHIFT with `cnt`<7 wait.
- Producer handshake
  - The producer keeps `i_req` and its byte stable until it sees `o_ack`.
  - In the cycle after the ack, the producer either drops `i_req` or presents its next byte.
  - Dropping `i_req` before the ack is a protocol violation; the byte already captured is still sent.
- `o_ack` is registered and its bits are mutually exclusive.
- Reset
  - Reset is allowed at any time, including mid-SHIFT. The transfer in progress is abandoned with no ack replay.
  - Reset values: state IDLE; `o_latchen`, `o_txen`, `o_ack`, `o_busy`, `o_data`, `o_owner`, `cnt` all 0; round-robin pointer 0.
- `o_busy` = (state != IDLE).

## Timing
- Request seen in IDLE at edge t0:
  - Cycle t0+1 is LATCH (`o_latchen` and `o_ack` pulse).
  - Cycles t0+2..t0+9 are SHIFT with `o_txen` high.
- `serialtx.o_out` carries byte bit 7 after the first SHIFT edge and bit 0 after the eighth SHIFT edge. When `o_txen` is low, `serialtx.o_out` is high-Z.
- Back-to-back bytes take 9 cycles each (LATCH + 8 SHIFT) with no IDLE cycle between them.
- Latency from `i_req` rising (in IDLE) to `o_ack` is 1 cycle.

## Configuration
- `SERIALTX_ARB_RR_EN` defined (round robin):
  - The pointer `rr` holds (last winner + 1) mod N_REQ.
  - The search starts at `rr` and wraps past N_REQ-1 to 0.
  - `rr` is updated on every grant.
- `SERIALTX_ARB_RR_EN` undefined (fixed priority):
  - The lowest-index requester wins.
  - There is no pointer register.

## Structure
- Package `serialtx_pkg` contains:
  - `BYTE_W` = 8.
  - `BITS_PER_BYTE` = 8.
  - The state enum `serialtx_arb_state_t` (IDLE, LATCH, SHIFT).
- Sub-module `serialtx_rr_pick` is a combinational picker.
  - Inputs: `req[N_REQ]` and `ptr[IDW]`.
  - Outputs: `valid` and `idx`.
  - Fixed-priority mode ties `ptr` to 0.
- The top level instantiates the picker plus the FSM. It does not instantiate `serialtx`; that is wired at the parent.

## Test plan
- Single request: `i_req`=4'b0001, byte 0xA5 in IDLE.
  - `o_ack`=0001 one cycle later; `o_txen` high exactly 8 cycles.
  - Serializer output is 1,0,1,0,0,1,0,1; then IDLE with `o_busy`=0.
- All four requesters requesting continuously, bytes 0x11/0x22/0x33/0x44, RR enabled:
  - Grants in order 0,1,2,3,0,…, each 9 cycles apart.
  - Never an IDLE cycle; `o_latchen` and `o_txen` never both high.
- Same stimulus with the macro undefined:
  - Requester 0 wins every slot while held. After it drops, requester 1 gets the next slot.
- Late arrival: `i_req[2]` rises while `cnt`=3.
  - It is not acked until the LATCH following the `cnt`=7 cycle.
- Reset mid-SHIFT, asserted at `cnt`=4:
  - The next cycle shows all outputs 0 and state IDLE.
  - With `i_req`=4'b1000 held, the first grant after release goes to requester 3 in RR mode.
- Pointer wrap: last grant to requester 3, then `i_req`=4'b1001.
  - Requester 0 wins next (RR); requester 3 wins the following slot.

Source files
------------

// File: rtl/serialtx_arb_pkg.sv
// Shared types and constants for the serialtx transmit arbiter.
package serialtx_pkg;

    localparam int BYTE_W        = 8;
    localparam int BITS_PER_BYTE = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LATCH = 2'd1,
        SHIFT = 2'd2
    } serialtx_arb_state_t;

endpackage

// File: rtl/serialtx_arb_rr_pick.sv
// Combinational requester picker: first set bit of req, searching upward
// from ptr and wrapping past N_REQ-1 back to 0. ptr=0 gives fixed priority.
module serialtx_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   idx
);

    localparam int            KW = IDW + 1;
    localparam logic [KW-1:0] NR = KW'(N_REQ);

    logic [KW-1:0] k;

    // Walk offsets from farthest to nearest so the nearest pending requester wins last.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        k     = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            k = {1'b0, ptr} + KW'(i);
            if (k >= NR) begin
                k = k - NR;
            end
            if (req[k[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = k[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/serialtx_arb.sv
// Transmit scheduler sharing one serialtx PISO between N_REQ byte producers.
// Each grant is one LATCH cycle (latch pulse + ack) followed by 8 SHIFT
// cycles with txen high; the next grant is taken in the last SHIFT cycle so
// back-to-back bytes leave no idle gap.
// Build option: define SERIALTX_ARB_RR_EN for round-robin arbitration;
// without it the lowest-index requester always wins.
module serialtx_arb
    import serialtx_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = $clog2(N_REQ)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_REQ-1:0]        i_req,
    input  logic [BYTE_W*N_REQ-1:0] i_data,
    output logic [N_REQ-1:0]        o_ack,
    output logic [BYTE_W-1:0]       o_data,
    output logic                    o_latchen,
    output logic                    o_txen,
    output logic [IDW-1:0]          o_owner,
    output logic                    o_busy
);

    localparam logic [2:0]       CNT_LAST = 3'(BITS_PER_BYTE - 1);
    localparam logic [N_REQ-1:0] ACK_ONE  = N_REQ'(1);

    serialtx_arb_state_t             state_q;
    logic [2:0]                      cnt_q;
    logic [BYTE_W-1:0]               data_q;
    logic [IDW-1:0]                  owner_q;
    logic                            latchen_q;
    logic                            txen_q;
    logic [N_REQ-1:0]                ack_q;
    logic                            busy_q;

    logic [N_REQ-1:0][BYTE_W-1:0]    data_arr;
    logic [IDW-1:0]                  pick_ptr;
    logic                            pick_valid;
    logic [IDW-1:0]                  pick_idx;
    logic                            grant;

    assign data_arr = i_data;

    // Requests are only looked at in IDLE or in the final SHIFT cycle.
    assign grant = pick_valid &&
                   ((state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST)));

`ifdef SERIALTX_ARB_RR_EN
    logic [IDW-1:0] rr_q;

    assign pick_ptr = rr_q;

    // Pointer moves to one past the last winner on every grant.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_q <= '0;
        end else if (grant) begin
            rr_q <= (pick_idx == IDW'(N_REQ - 1)) ? '0 : pick_idx + IDW'(1);
        end
    end
`else
    assign pick_ptr = '0;
`endif

    serialtx_rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_pick (
        .req   (i_req),
        .ptr   (pick_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Sequencer: all serializer controls are registered so latchen and txen
    // can never overlap; a grant overrides the end-of-shift return to IDLE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            owner_q   <= '0;
            latchen_q <= 1'b0;
            txen_q    <= 1'b0;
            ack_q     <= '0;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: ;
                LATCH: begin
                    state_q   <= SHIFT;
                    cnt_q     <= '0;
                    latchen_q <= 1'b0;
                    ack_q     <= '0;
                    txen_q    <= 1'b1;
                end
                SHIFT: begin
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        txen_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txen_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase

            if (grant) begin
                state_q   <= LATCH;
                data_q    <= data_arr[pick_idx];
                owner_q   <= pick_idx;
                latchen_q <= 1'b1;
                ack_q     <= ACK_ONE << pick_idx;
                txen_q    <= 1'b0;
                busy_q    <= 1'b1;
            end
        end
    end

    assign o_ack     = ack_q;
    assign o_data    = data_q;
    assign o_latchen = latchen_q;
    assign o_txen    = txen_q;
    assign o_owner   = owner_q;
    assign o_busy    = busy_q;

endmodule
